// File: rtl/osc_ring_seq_if.sv
// Control/status bundle between the ring-oscillator sequencer and its loop controller.
// master = loop controller side, slave = osc_ring_seq.
interface osc_ring_seq_if #(
   parameter int unsigned NSTAGE = 5,
   parameter int unsigned LSB_W  = 5,
   parameter int unsigned MSB_W  = 8,
   parameter int unsigned PERB_W = 4
);
   localparam int unsigned MB_W = $clog2(MSB_W + 1);
   localparam int unsigned PB_W = NSTAGE * PERB_W;

   logic              en_req;
   logic [1:0]        inj_mode;
   logic              code_load;
   logic [LSB_W-1:0]  code_lsb;
   logic [MB_W-1:0]   code_msb;
   logic [PB_W-1:0]   perb_base;
   logic              glob_en;
   logic              osc_hold;
   logic              inj_en;
   logic [LSB_W-1:0]  delay_con_lsb;
   logic [MSB_W-1:0]  delay_con_msb;
   logic [PB_W-1:0]   con_perb;
   logic              running;
   logic              code_pend;

   modport master (
      output en_req, inj_mode, code_load, code_lsb, code_msb, perb_base,
      input  glob_en, osc_hold, inj_en, delay_con_lsb, delay_con_msb, con_perb, running, code_pend
   );

   modport slave (
      input  en_req, inj_mode, code_load, code_lsb, code_msb, perb_base,
      output glob_en, osc_hold, inj_en, delay_con_lsb, delay_con_msb, con_perb, running, code_pend
   );
endinterface

// File: rtl/osc_ring_seq.sv
// Start-up/injection sequencer and glitch-safe varactor code driver for an odd-stage ring oscillator.
// Optional per-stage LFSR dither on con_perb when OSC_PERB_DITHER_EN is defined.
module osc_ring_seq #(
   parameter int unsigned NSTAGE   = 5,
   parameter int unsigned LSB_W    = 5,
   parameter int unsigned MSB_W    = 8,
   parameter int unsigned PERB_W   = 4,
   parameter int unsigned HOLD_CYC = 4,
   parameter int unsigned INJ_DIV  = 8
) (
   input  logic          ref_clk,
   input  logic          rst,
   osc_ring_seq_if.slave bus
);
   localparam int unsigned MB_W = $clog2(MSB_W + 1);
   localparam int unsigned PB_W = NSTAGE * PERB_W;
   localparam int unsigned HC_W = (HOLD_CYC > 1) ? $clog2(HOLD_CYC) : 1;
   localparam int unsigned ID_W = $clog2(INJ_DIV);

   typedef enum logic [1:0] {S_OFF, S_HOLD, S_INJ, S_RUN} state_t;

   state_t            state, state_d;
   logic [HC_W-1:0]   hold_cnt, hold_cnt_d;
   logic [ID_W-1:0]   inj_cnt, inj_cnt_d;
   logic              glob_q, glob_d, hold_q, hold_d, inj_q, inj_d, run_q, run_d;
   logic [LSB_W-1:0]  pend_lsb, lsb_q;
   logic [MB_W-1:0]   pend_msb;
   logic [MSB_W-1:0]  msb_q, therm_c;
   logic              pend_q;
   logic [PB_W-1:0]   perb_q, perb_d;
   logic              periodic_c, apply_c;

   assign periodic_c = bus.inj_mode[1];

   // Next state, counters and next-cycle output values
   always_comb begin
      state_d    = state;
      hold_cnt_d = hold_cnt;
      inj_cnt_d  = inj_cnt;
      glob_d     = 1'b0;
      hold_d     = 1'b0;
      inj_d      = 1'b0;
      run_d      = 1'b0;
      if (!bus.en_req) begin
         state_d = S_OFF;
      end else begin
         case (state)
            S_OFF: begin
               state_d    = S_HOLD;
               hold_cnt_d = HC_W'(HOLD_CYC - 1);
            end
            S_HOLD: begin
               if (hold_cnt == '0) begin
                  state_d   = (bus.inj_mode != 2'd0) ? S_INJ : S_RUN;
                  inj_cnt_d = ID_W'(INJ_DIV - 1);
               end else begin
                  hold_cnt_d = hold_cnt - 1'b1;
               end
            end
            S_INJ: begin
               state_d   = S_RUN;
               inj_cnt_d = ID_W'(INJ_DIV - 1);
            end
            S_RUN: begin
               if (!periodic_c || inj_cnt == '0) inj_cnt_d = ID_W'(INJ_DIV - 1);
               else                              inj_cnt_d = inj_cnt - 1'b1;
            end
            default: state_d = S_OFF;
         endcase
      end
      case (state_d)
         S_HOLD: begin glob_d = 1'b1; hold_d = 1'b1; end
         S_INJ:  begin glob_d = 1'b1; hold_d = 1'b1; inj_d = 1'b1; end
         S_RUN:  begin glob_d = 1'b1; run_d = 1'b1; end
         default: ;
      endcase
      // Periodic pulse lands in the cycle the counter reads zero, giving an exact INJ_DIV period
      if (state == S_RUN && state_d == S_RUN && periodic_c && inj_cnt_d == '0) inj_d = 1'b1;
   end

   // Codes only change where the ring is stopped, non-periodic, or just re-injected
   always_comb begin
      apply_c = 1'b0;
      if (pend_q) begin
         case (state)
            S_OFF, S_HOLD: apply_c = 1'b1;
            S_RUN:         apply_c = !periodic_c || inj_q;
            default:       apply_c = 1'b0;
         endcase
      end
      therm_c = '0;
      for (int k = 0; k < int'(MSB_W); k++) therm_c[k] = (MB_W'(k) < pend_msb);
   end

`ifdef OSC_PERB_DITHER_EN
   logic [15:0] lfsr;
   logic [15:0] rot_c;

   always_ff @(posedge ref_clk or posedge rst) begin
      if (rst)                lfsr <= 16'hACE1;
      else if (state == S_RUN) lfsr <= {lfsr[0] ^ lfsr[2] ^ lfsr[3] ^ lfsr[5], lfsr[15:1]};
   end

   always_comb begin
      perb_d = bus.perb_base;
      rot_c  = lfsr;
      if (state == S_RUN) begin
         for (int i = 0; i < int'(NSTAGE); i++) begin
            rot_c = (lfsr >> (i % 16)) | (lfsr << ((16 - (i % 16)) % 16));
            perb_d[i*PERB_W +: PERB_W] = bus.perb_base[i*PERB_W +: PERB_W] + PERB_W'(rot_c);
         end
      end
   end
`else
   assign perb_d = bus.perb_base;
`endif

   always_ff @(posedge ref_clk or posedge rst) begin
      if (rst) begin
         state    <= S_OFF;
         hold_cnt <= '0;
         inj_cnt  <= '0;
         glob_q   <= 1'b0;
         hold_q   <= 1'b0;
         inj_q    <= 1'b0;
         run_q    <= 1'b0;
         pend_lsb <= '0;
         pend_msb <= '0;
         pend_q   <= 1'b0;
         lsb_q    <= '0;
         msb_q    <= '0;
         perb_q   <= '0;
      end else begin
         state    <= state_d;
         hold_cnt <= hold_cnt_d;
         inj_cnt  <= inj_cnt_d;
         glob_q   <= glob_d;
         hold_q   <= hold_d;
         inj_q    <= inj_d;
         run_q    <= run_d;
         perb_q   <= perb_d;
         // A load coinciding with an apply slot wins the pending flag; it waits for the next slot
         if (bus.code_load) begin
            pend_lsb <= bus.code_lsb;
            pend_msb <= bus.code_msb;
            pend_q   <= 1'b1;
         end else if (apply_c) begin
            pend_q   <= 1'b0;
         end
         if (apply_c) begin
            lsb_q <= pend_lsb;
            msb_q <= therm_c;
         end
      end
   end

   assign bus.glob_en       = glob_q;
   assign bus.osc_hold      = hold_q;
   assign bus.inj_en        = inj_q;
   assign bus.running       = run_q;
   assign bus.code_pend     = pend_q;
   assign bus.delay_con_lsb = lsb_q;
   assign bus.delay_con_msb = msb_q;
   assign bus.con_perb      = perb_q;
endmodule

// File: tb/tb_osc_ring_seq.sv
// Directed scoreboard bench for osc_ring_seq with default parameters.
// Define OSC_PERB_DITHER_EN for both bench and RTL to exercise the dither path.
module tb_osc_ring_seq;
   logic ref_clk = 1'b0;
   logic rst;
   int   checks   = 0;
   int   failures = 0;

   typedef struct {
      string       tag;
      logic [31:0] val;
   } exp_t;

   exp_t       sb[$];
   int         pulse_q[$];
   logic [4:0] ctrl;
   logic [4:0] t1_exp [7];
   logic [15:0] m_lfsr;
   logic [19:0] m_base;

   osc_ring_seq_if bus ();

   osc_ring_seq dut (
      .ref_clk (ref_clk),
      .rst     (rst),
      .bus     (bus.slave)
   );

   always #5 ref_clk = ~ref_clk;

   assign ctrl = {bus.glob_en, bus.osc_hold, bus.inj_en, bus.running, bus.code_pend};

   task automatic push(input string tag, input logic [31:0] v);
      exp_t e;
      e.tag = tag;
      e.val = v;
      sb.push_back(e);
   endtask

   task automatic pop_check(input logic [31:0] obs);
      exp_t e;
      checks++;
      if (sb.size() == 0) begin
         failures++;
         $error("FAIL sb_empty observed=%0h expected=<none>", obs);
      end else begin
         e = sb.pop_front();
         assert (obs === e.val)
         else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", e.tag, obs, e.val);
         end
      end
   endtask

   task automatic tick();
      @(negedge ref_clk);
   endtask

`ifdef OSC_PERB_DITHER_EN
   function automatic logic [19:0] dither(input logic [19:0] base, input logic [15:0] l);
      logic [19:0] r;
      logic [15:0] rot;
      r = '0;
      for (int i = 0; i < 5; i++) begin
         rot = (l >> i) | (l << (16 - i));
         r[i*4 +: 4] = base[i*4 +: 4] + rot[3:0];
      end
      return r;
   endfunction
`endif

   initial begin
      #100000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      t1_exp = '{5'b11000, 5'b11000, 5'b11000, 5'b11000, 5'b11100, 5'b10010, 5'b10010};
      rst = 1'b1;
      bus.en_req = 1'b0; bus.inj_mode = 2'd0; bus.code_load = 1'b0;
      bus.code_lsb = '0; bus.code_msb = '0; bus.perb_base = 20'h5A3C1;
      repeat (2) tick();

      // reset state
      push("rst_ctrl", 0); pop_check(32'(ctrl));
      push("rst_lsb", 0);  pop_check(32'(bus.delay_con_lsb));
      push("rst_msb", 0);  pop_check(32'(bus.delay_con_msb));
      push("rst_perb", 0); pop_check(32'(bus.con_perb));
      rst = 1'b0;
      tick();
      push("off_ctrl", 0);       pop_check(32'(ctrl));
      push("off_perb", 20'h5A3C1); pop_check(32'(bus.con_perb));

      // start-up: 4 HOLD, 1 INJ, then RUN
      bus.en_req = 1'b1; bus.inj_mode = 2'd1;
      for (int i = 0; i < 7; i++) begin
         push("t1_ctrl", 32'(t1_exp[i]));
         tick();
         pop_check(32'(ctrl));
      end

      // periodic injection
      bus.inj_mode = 2'd2;
      for (int i = 1; i <= 48; i++) begin
         tick();
         if (bus.inj_en) pulse_q.push_back(i);
      end
      push("t2_npulse", 6);
      pop_check(32'(pulse_q.size()));
      for (int p = 0; p < 6; p++) begin
         push("t2_pulse", 32'(7 + 8 * p));
         pop_check((pulse_q.size() > 0) ? 32'(pulse_q.pop_front()) : 32'hFFFF_FFFF);
      end

      // code update held until the cycle after the next inj_en (pulse at 55)
      bus.code_load = 1'b1; bus.code_lsb = 5'h13; bus.code_msb = 4'd3;
      tick();                                     // 49
      bus.code_load = 1'b0;
      push("t3_pend", 5'b10011); pop_check(32'(ctrl));
      for (int i = 50; i <= 55; i++) begin
         tick();
         push("t3_lsb_hold", 0); pop_check(32'(bus.delay_con_lsb));
      end
      push("t3_inj", 5'b10111); pop_check(32'(ctrl));
      tick();                                     // 56
      push("t3_lsb", 5'h13); pop_check(32'(bus.delay_con_lsb));
      push("t3_msb", 8'h07); pop_check(32'(bus.delay_con_msb));
      push("t3_ctrl", 5'b10010); pop_check(32'(ctrl));

      // mode 0: immediate slot, saturation, zero, coincident load
      bus.inj_mode = 2'd0;
      bus.code_load = 1'b1; bus.code_lsb = 5'h1F; bus.code_msb = 4'd15;
      tick();                                     // 57
      bus.code_load = 1'b0;
      push("t4_pend", 5'b10011); pop_check(32'(ctrl));
      push("t4_msb_old", 8'h07); pop_check(32'(bus.delay_con_msb));
      tick();                                     // 58
      push("t4_msb_sat", 8'hFF); pop_check(32'(bus.delay_con_msb));
      push("t4_lsb", 5'h1F);     pop_check(32'(bus.delay_con_lsb));
      bus.code_load = 1'b1; bus.code_lsb = 5'h02; bus.code_msb = 4'd0;
      tick();                                     // 59
      push("t4_msb_wait", 8'hFF); pop_check(32'(bus.delay_con_msb));
      bus.code_lsb = 5'h07; bus.code_msb = 4'd5;
      tick();                                     // 60
      bus.code_load = 1'b0;
      push("t4_msb_zero", 8'h00); pop_check(32'(bus.delay_con_msb));
      push("t4_lsb2", 5'h02);     pop_check(32'(bus.delay_con_lsb));
      push("t4_pend2", 5'b10011); pop_check(32'(ctrl));
      tick();                                     // 61
      push("t4_msb5", 8'h1F); pop_check(32'(bus.delay_con_msb));
      push("t4_lsb7", 5'h07); pop_check(32'(bus.delay_con_lsb));
      push("t4_ctrl", 5'b10010); pop_check(32'(ctrl));

      // en_req drop in RUN, then in HOLD
      bus.en_req = 1'b0;
      tick();                                     // 62
      push("t5_run_drop", 0); pop_check(32'(ctrl));
      push("t5_keep_msb", 8'h1F); pop_check(32'(bus.delay_con_msb));
      bus.perb_base = 20'h12345; bus.en_req = 1'b1; bus.inj_mode = 2'd1;
      tick();                                     // 63
      push("t5_hold", 5'b11000); pop_check(32'(ctrl));
      push("t5_perb", 20'h12345); pop_check(32'(bus.con_perb));
      bus.en_req = 1'b0;
      tick();                                     // 64
      push("t5_hold_drop", 0); pop_check(32'(ctrl));
      bus.en_req = 1'b1; bus.inj_mode = 2'd2;
      repeat (5) tick();                          // 69
      push("t5_inj", 5'b11100); pop_check(32'(ctrl));
      tick();                                     // 70
      push("t5_run", 5'b10010); pop_check(32'(ctrl));
      bus.code_load = 1'b1; bus.code_lsb = 5'h09; bus.code_msb = 4'd2;
      tick();                                     // 71
      bus.code_load = 1'b0;
      push("t5_pend", 5'b10011); pop_check(32'(ctrl));

      // async reset mid-RUN, pending discarded
      #2;
      rst = 1'b1; bus.en_req = 1'b0;
      #1;
      push("t5_arst_ctrl", 0); pop_check(32'(ctrl));
      push("t5_arst_lsb", 0);  pop_check(32'(bus.delay_con_lsb));
      push("t5_arst_msb", 0);  pop_check(32'(bus.delay_con_msb));
      push("t5_arst_perb", 0); pop_check(32'(bus.con_perb));
      tick();
      rst = 1'b0;
      repeat (3) tick();
      push("t5_post_ctrl", 0); pop_check(32'(ctrl));
      push("t5_post_lsb", 0);  pop_check(32'(bus.delay_con_lsb));

      // per-stage perturbation in RUN
      m_base = 20'hFFFFF;
      bus.perb_base = m_base; bus.en_req = 1'b1; bus.inj_mode = 2'd1;
      repeat (6) tick();
      push("t6_run", 5'b10010); pop_check(32'(ctrl));
      m_lfsr = 16'hACE1;
      for (int k = 0; k < 8; k++) begin
`ifdef OSC_PERB_DITHER_EN
         push("t6_perb", 32'(dither(m_base, m_lfsr)));
`else
         push("t6_perb", 32'(m_base));
`endif
         tick();
         pop_check(32'(bus.con_perb));
         m_lfsr = {m_lfsr[0] ^ m_lfsr[2] ^ m_lfsr[3] ^ m_lfsr[5], m_lfsr[15:1]};
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
